lbuffer: RTL and testbench

Load buffer of the Tomasulo RISC-V core. It accepts computed load addresses from the address unit and holds them in an in-order FIFO. It issues them one at a time to the memory controller, sign/zero-extends the returned data, and broadcasts the result on the load-buffer half of the common data bus. It also drives the `lbuffer_rs_rdy` credit signal. The reservation station consults that signal before releasing any load to the address unit.

---
 rtl/lbuffer.sv | 215 +++++++++++++++++++++
 tb/tb_lbuffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lbuffer.sv
// Load buffer: in-order FIFO of computed load addresses, one outstanding
// memory read at a time, sign/zero extension of returned data and a
// one-cycle broadcast on the load-buffer half of the common data bus.

package lbuffer_pkg;
    localparam int AddressWidth  = 32;
    localparam int IDWidth       = 32;
    localparam int ROBWidth      = 5;
    localparam int InstTypeWidth = 6;

    localparam logic [InstTypeWidth-1:0] NOP = 6'd0;
    localparam logic [InstTypeWidth-1:0] LB  = 6'd10;
    localparam logic [InstTypeWidth-1:0] LH  = 6'd11;
    localparam logic [InstTypeWidth-1:0] LW  = 6'd12;
    localparam logic [InstTypeWidth-1:0] LBU = 6'd13;
    localparam logic [InstTypeWidth-1:0] LHU = 6'd14;
endpackage

module lbuffer
    import lbuffer_pkg::*;
#(
    parameter int LBCount = 8,
    parameter int LBWidth = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [AddressWidth-1:0]  addrunit_lbuffer_addr_in,
    input  logic [ROBWidth-1:0]      addrunit_lbuffer_dest_in,
    input  logic [InstTypeWidth-1:0] addrunit_lbuffer_opcode_in,
    output logic                     lbuffer_rs_rdy_out,
    output logic                     lbuffer_mc_en_out,
    output logic [AddressWidth-1:0]  lbuffer_mc_addr_out,
    output logic [1:0]               lbuffer_mc_size_out,
    input  logic                     mc_lbuffer_rdy_in,
    input  logic [31:0]              mc_lbuffer_data_in,
    input  logic                     rob_lbuffer_rst_in,
    output logic [ROBWidth-1:0]      cdb_lbuffer_b_out,
    output logic [IDWidth-1:0]       cdb_lbuffer_result_out
);

    localparam logic [LBWidth:0] COUNT_MAX = (LBWidth+1)'(LBCount);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Access size seen by the memory controller: 0 byte, 1 half, 2 word.
    function automatic logic [1:0] size_of(input logic [InstTypeWidth-1:0] op);
        logic [1:0] sz;
        case (op)
            LB, LBU: sz = 2'd0;
            LH, LHU: sz = 2'd1;
            LW:      sz = 2'd2;
            default: sz = 2'd0;
        endcase
        return sz;
    endfunction

    // Sign/zero extension of LSB-aligned raw read data.
    function automatic logic [31:0] extend(input logic [InstTypeWidth-1:0] op,
                                           input logic [31:0] data);
        logic [31:0] res;
        case (op)
            LB:      res = {{24{data[7]}}, data[7:0]};
            LBU:     res = {24'd0, data[7:0]};
            LH:      res = {{16{data[15]}}, data[15:0]};
            LHU:     res = {16'd0, data[15:0]};
            LW:      res = data;
            default: res = data;
        endcase
        return res;
    endfunction

    logic [AddressWidth-1:0]  addr_mem_r [LBCount];
    logic [ROBWidth-1:0]      dest_mem_r [LBCount];
    logic [InstTypeWidth-1:0] op_mem_r   [LBCount];

    logic [LBWidth-1:0]      head_r, tail_r;
    logic [LBWidth:0]        count_r;
    state_t                  state_r;
    logic                    mc_en_r;
    logic [AddressWidth-1:0] mc_addr_r;
    logic [1:0]              mc_size_r;
    logic [ROBWidth-1:0]     cdb_b_r;
    logic [IDWidth-1:0]      cdb_result_r;

    logic                    enq_s, pop_s;
    logic [LBWidth-1:0]      head_nxt_s, tail_nxt_s;
    logic [LBWidth:0]        count_nxt_s;
    state_t                  state_nxt_s;
    logic                    mc_en_nxt_s;
    logic [AddressWidth-1:0] mc_addr_nxt_s;
    logic [1:0]              mc_size_nxt_s;
    logic [ROBWidth-1:0]     cdb_b_nxt_s;
    logic [IDWidth-1:0]      cdb_result_nxt_s;

    // Two loads may already be travelling RS -> address unit, so keep three free slots.
    assign lbuffer_rs_rdy_out     = ((COUNT_MAX - count_r) >= (LBWidth+1)'(3));
    assign lbuffer_mc_en_out      = mc_en_r;
    assign lbuffer_mc_addr_out    = mc_addr_r;
    assign lbuffer_mc_size_out    = mc_size_r;
    assign cdb_lbuffer_b_out      = cdb_b_r;
    assign cdb_lbuffer_result_out = cdb_result_r;

    // Next-state, memory request, broadcast and pointer computation.
    always_comb begin
        pop_s            = 1'b0;
        state_nxt_s      = state_r;
        mc_en_nxt_s      = mc_en_r;
        mc_addr_nxt_s    = mc_addr_r;
        mc_size_nxt_s    = mc_size_r;
        cdb_b_nxt_s      = {ROBWidth{1'b0}};
        cdb_result_nxt_s = cdb_result_r;

        // A full-buffer enqueue is dropped; a flush discards any same-cycle enqueue.
        if ((addrunit_lbuffer_opcode_in != NOP) && (count_r != COUNT_MAX) &&
            !rob_lbuffer_rst_in) begin
            enq_s = 1'b1;
        end else begin
            enq_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (!rob_lbuffer_rst_in && (count_r != {(LBWidth+1){1'b0}})) begin
                    mc_en_nxt_s   = 1'b1;
                    mc_addr_nxt_s = addr_mem_r[head_r];
                    mc_size_nxt_s = size_of(op_mem_r[head_r]);
                    state_nxt_s   = ST_WAIT;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mc_lbuffer_rdy_in) begin
                    mc_en_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                    // A flush arriving with the data still retires the read, silently.
                    if (!rob_lbuffer_rst_in) begin
                        pop_s            = 1'b1;
                        cdb_b_nxt_s      = dest_mem_r[head_r];
                        cdb_result_nxt_s = extend(op_mem_r[head_r], mc_lbuffer_data_in);
                    end else begin
                        pop_s            = 1'b0;
                    end
                end else if (rob_lbuffer_rst_in) begin
                    // The controller needs the request held until it is served.
                    state_nxt_s = ST_DISCARD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (mc_lbuffer_rdy_in) begin
                    mc_en_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                mc_en_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (rob_lbuffer_rst_in) begin
            head_nxt_s  = {LBWidth{1'b0}};
            tail_nxt_s  = {LBWidth{1'b0}};
            count_nxt_s = {(LBWidth+1){1'b0}};
        end else begin
            head_nxt_s  = head_r + {{(LBWidth-1){1'b0}}, pop_s};
            tail_nxt_s  = tail_r + {{(LBWidth-1){1'b0}}, enq_s};
            count_nxt_s = count_r + {{LBWidth{1'b0}}, enq_s} - {{LBWidth{1'b0}}, pop_s};
        end
    end

    // Control and output registers; reset wins over the global enable.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_r       <= {LBWidth{1'b0}};
            tail_r       <= {LBWidth{1'b0}};
            count_r      <= {(LBWidth+1){1'b0}};
            state_r      <= ST_IDLE;
            mc_en_r      <= 1'b0;
            mc_addr_r    <= {AddressWidth{1'b0}};
            mc_size_r    <= 2'd0;
            cdb_b_r      <= {ROBWidth{1'b0}};
            cdb_result_r <= {IDWidth{1'b0}};
        end else if (rdy_in) begin
            head_r       <= head_nxt_s;
            tail_r       <= tail_nxt_s;
            count_r      <= count_nxt_s;
            state_r      <= state_nxt_s;
            mc_en_r      <= mc_en_nxt_s;
            mc_addr_r    <= mc_addr_nxt_s;
            mc_size_r    <= mc_size_nxt_s;
            cdb_b_r      <= cdb_b_nxt_s;
            cdb_result_r <= cdb_result_nxt_s;
        end
    end

    // FIFO entry storage written at the tail; contents need no reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && enq_s) begin
            addr_mem_r[tail_r] <= addrunit_lbuffer_addr_in;
            dest_mem_r[tail_r] <= addrunit_lbuffer_dest_in;
            op_mem_r[tail_r]   <= addrunit_lbuffer_opcode_in;
        end
    end

endmodule

// File: tb/tb_lbuffer.sv
// Directed self-checking bench for the load buffer.
module tb_lbuffer;
    import lbuffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [31:0] addr_in;
    logic [4:0]  dest_in;
    logic [5:0]  opcode_in;
    logic        rs_rdy, mc_en;
    logic [31:0] mc_addr;
    logic [1:0]  mc_size;
    logic        mc_rdy;
    logic [31:0] mc_data;
    logic        rob_rst;
    logic [4:0]  cdb_b;
    logic [31:0] cdb_res;

    int checks_total  = 0;
    int checks_passed = 0;

    lbuffer dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .rdy_in                     (rdy_in),
        .addrunit_lbuffer_addr_in   (addr_in),
        .addrunit_lbuffer_dest_in   (dest_in),
        .addrunit_lbuffer_opcode_in (opcode_in),
        .lbuffer_rs_rdy_out         (rs_rdy),
        .lbuffer_mc_en_out          (mc_en),
        .lbuffer_mc_addr_out        (mc_addr),
        .lbuffer_mc_size_out        (mc_size),
        .mc_lbuffer_rdy_in          (mc_rdy),
        .mc_lbuffer_data_in         (mc_data),
        .rob_lbuffer_rst_in         (rob_rst),
        .cdb_lbuffer_b_out          (cdb_b),
        .cdb_lbuffer_result_out     (cdb_res)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_total++;
        if (obs === exp_v) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic enq(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] dest);
        opcode_in = op;
        addr_in   = addr;
        dest_in   = dest;
        tick();
        opcode_in = NOP;
    endtask

    task automatic wait_mc_en();
        int n = 0;
        while (mc_en !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq("mc_en_wait", 32'(mc_en), 32'd1);
    endtask

    task automatic serve(input logic [31:0] data, input logic [31:0] exp_addr,
                         input logic [1:0] exp_size, input logic [4:0] exp_dest,
                         input logic [31:0] exp_res);
        wait_mc_en();
        check_eq("mc_addr", mc_addr, exp_addr);
        check_eq("mc_size", 32'(mc_size), 32'(exp_size));
        tick();
        check_eq("mc_en_hold", 32'(mc_en), 32'd1);
        mc_rdy  = 1'b1;
        mc_data = data;
        tick();
        mc_rdy  = 1'b0;
        mc_data = 32'd0;
        check_eq("cdb_b", 32'(cdb_b), 32'(exp_dest));
        check_eq("cdb_result", cdb_res, exp_res);
        check_eq("mc_en_drop", 32'(mc_en), 32'd0);
        tick();
        check_eq("cdb_b_clear", 32'(cdb_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b0;
        addr_in   = 32'd0;
        dest_in   = 5'd0;
        opcode_in = NOP;
        mc_rdy    = 1'b0;
        mc_data   = 32'd0;
        rob_rst   = 1'b0;

        // Reset with rdy_in low: reset must still take effect.
        tick();
        tick();
        check_eq("rst_mc_en",   32'(mc_en),   32'd0);
        check_eq("rst_mc_addr", mc_addr,      32'd0);
        check_eq("rst_mc_size", 32'(mc_size), 32'd0);
        check_eq("rst_cdb_b",   32'(cdb_b),   32'd0);
        check_eq("rst_cdb_res", cdb_res,      32'd0);
        check_eq("rst_rs_rdy",  32'(rs_rdy),  32'd1);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        tick();

        // LB sign extension and earliest issue latency.
        enq(LB, 32'h100, 5'd3);
        check_eq("lat_edge_n", 32'(mc_en), 32'd0);
        tick();
        check_eq("lat_edge_n1", 32'(mc_en), 32'd1);
        serve(32'h0000_0080, 32'h100, 2'd0, 5'd3, 32'hFFFF_FF80);

        // LHU / LH / LW in order.
        enq(LHU, 32'h200, 5'd1);
        enq(LH,  32'h204, 5'd2);
        enq(LW,  32'h208, 5'd5);
        serve(32'h0001_F0F0, 32'h200, 2'd1, 5'd1, 32'h0000_F0F0);
        serve(32'h0001_F0F0, 32'h204, 2'd1, 5'd2, 32'hFFFF_F0F0);
        serve(32'h0001_F0F0, 32'h208, 2'd2, 5'd5, 32'h0001_F0F0);

        // Credit, full-drop and pointer wrap over three rounds.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                enq(LW, 32'h1000 + 32'(r) * 32'h100 + 32'(i) * 32'd4, 5'(i + 1));
                check_eq("rs_rdy_fill", 32'(rs_rdy), (i + 1 <= 5) ? 32'd1 : 32'd0);
            end
            check_eq("count_full", 32'(dut.count_r), 32'd8);
            enq(LW, 32'hDEAD_0000, 5'd15);
            check_eq("count_full_drop", 32'(dut.count_r), 32'd8);
            for (int i = 0; i < 8; i++) begin
                serve(32'h1111_1111 * 32'(i + 1), 32'h1000 + 32'(r) * 32'h100 + 32'(i) * 32'd4,
                      2'd2, 5'(i + 1), 32'h1111_1111 * 32'(i + 1));
            end
            check_eq("count_drained", 32'(dut.count_r), 32'd0);
            check_eq("rs_rdy_drained", 32'(rs_rdy), 32'd1);
            tick();
            tick();
            check_eq("no_extra_issue", 32'(mc_en), 32'd0);
        end

        // Flush in WAIT with four queued.
        for (int i = 0; i < 4; i++) begin
            enq(LW, 32'h2000 + 32'(i) * 32'd4, 5'(i + 1));
        end
        check_eq("fl_pre_en",   32'(mc_en), 32'd1);
        check_eq("fl_pre_addr", mc_addr,    32'h2000);
        rob_rst = 1'b1;
        tick();
        rob_rst = 1'b0;
        check_eq("fl_count",   32'(dut.count_r), 32'd0);
        check_eq("fl_rs_rdy",  32'(rs_rdy),      32'd1);
        check_eq("fl_en_held", 32'(mc_en),       32'd1);
        check_eq("fl_addr",    mc_addr,          32'h2000);
        tick();
        tick();
        check_eq("fl_en_held2", 32'(mc_en), 32'd1);
        check_eq("fl_no_cdb",   32'(cdb_b), 32'd0);
        mc_rdy  = 1'b1;
        mc_data = 32'h1234_5678;
        tick();
        mc_rdy  = 1'b0;
        mc_data = 32'd0;
        check_eq("fl_done_cdb", 32'(cdb_b), 32'd0);
        check_eq("fl_done_en",  32'(mc_en), 32'd0);
        tick();
        tick();
        check_eq("fl_idle_en", 32'(mc_en), 32'd0);
        enq(LBU, 32'h300, 5'd7);
        serve(32'hFFFF_FF85, 32'h300, 2'd0, 5'd7, 32'h0000_0085);

        // Flush with a same-cycle enqueue.
        opcode_in = LW;
        addr_in   = 32'h500;
        dest_in   = 5'd9;
        rob_rst   = 1'b1;
        tick();
        opcode_in = NOP;
        rob_rst   = 1'b0;
        check_eq("fe_count", 32'(dut.count_r), 32'd0);
        tick();
        tick();
        check_eq("fe_no_issue", 32'(mc_en), 32'd0);
        check_eq("fe_no_cdb",   32'(cdb_b), 32'd0);

        // rdy_in low freezes state, including a live CDB pulse.
        enq(LW, 32'h400, 5'd6);
        enq(LH, 32'h404, 5'd8);
        wait_mc_en();
        check_eq("frz_pre_addr", mc_addr, 32'h400);
        mc_rdy  = 1'b1;
        mc_data = 32'h0BAD_F00D;
        tick();
        mc_rdy    = 1'b0;
        mc_data   = 32'd0;
        rdy_in    = 1'b0;
        opcode_in = LW;
        addr_in   = 32'h999;
        dest_in   = 5'd12;
        check_eq("frz_cdb_b0",   32'(cdb_b), 32'd6);
        check_eq("frz_cdb_res0", cdb_res,    32'h0BAD_F00D);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("frz_cdb_b",   32'(cdb_b),       32'd6);
            check_eq("frz_cdb_res", cdb_res,          32'h0BAD_F00D);
            check_eq("frz_mc_en",   32'(mc_en),       32'd0);
            check_eq("frz_count",   32'(dut.count_r), 32'd1);
        end
        rdy_in    = 1'b1;
        opcode_in = NOP;
        tick();
        check_eq("thaw_cdb_b", 32'(cdb_b), 32'd0);
        check_eq("thaw_mc_en", 32'(mc_en), 32'd1);
        serve(32'h0000_8001, 32'h404, 2'd1, 5'd8, 32'hFFFF_8001);
        check_eq("final_count", 32'(dut.count_r), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
